// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared cache/memory geometry, mm_ctrl FSM states and latency default.
package segre_pkg;

   localparam int ADDR_SIZE         = 32;
   localparam int DCACHE_LANE_SIZE  = 512;
   localparam int DCACHE_BYTE_SIZE  = 6;
   localparam int MM_RD_LATENCY_DEF = 10;

   typedef enum logic [1:0] {
      MM_IDLE,
      MM_BUSY,
      MM_RESP
   } mm_ctrl_state_e;

endpackage

// File: rtl/segre_mm_array.sv
// rtl/segre_mm_array.sv - lane storage: one synchronous write port, one asynchronous read port.
module segre_mm_array
   import segre_pkg::*;
#(
   parameter int NUM_LANES = 1024,
   parameter int IDX_W     = $clog2(NUM_LANES)
) (
   input  logic                        clk_i,
   input  logic                        we_i,
   input  logic [IDX_W-1:0]            wr_idx_i,
   input  logic [DCACHE_LANE_SIZE-1:0] wr_data_i,
   input  logic [IDX_W-1:0]            rd_idx_i,
   output logic [DCACHE_LANE_SIZE-1:0] rd_data_o
);

   logic [DCACHE_LANE_SIZE-1:0] mem_q [NUM_LANES];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/segre_mm_ctrl.sv
// rtl/segre_mm_ctrl.sv - fixed-latency main-memory model; SEGRE_MM_STATS_EN adds read/write counters.
module segre_mm_ctrl
   import segre_pkg::*;
#(
   parameter int MM_RD_LATENCY = MM_RD_LATENCY_DEF,
   parameter int MM_NUM_LANES  = 1024
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        mm_rd_req_i,
   input  logic [ADDR_SIZE-1:0]        mm_addr_i,
   input  logic                        mm_wr_req_i,
   input  logic [ADDR_SIZE-1:0]        mm_wr_addr_i,
   input  logic [DCACHE_LANE_SIZE-1:0] mm_data_i,
   output logic                        mm_data_rdy_o,
   output logic [DCACHE_LANE_SIZE-1:0] mm_data_o,
   output logic                        mm_err_o
`ifdef SEGRE_MM_STATS_EN
   ,
   output logic [31:0]                 mm_rd_cnt_o,
   output logic [31:0]                 mm_wr_cnt_o
`endif
);

   localparam int IDX_W = $clog2(MM_NUM_LANES);

   mm_ctrl_state_e              state_q, state_d;
   logic [7:0]                  cnt_q, cnt_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [DCACHE_LANE_SIZE-1:0] data_q, data_d;
   logic                        rdy_q, rdy_d;
   logic                        err_q, err_d;

   logic [IDX_W-1:0]            rd_lane;
   logic [IDX_W-1:0]            wr_lane;
   logic [DCACHE_LANE_SIZE-1:0] arr_rd_data;
   logic                        arr_we;

   assign rd_lane = mm_addr_i[DCACHE_BYTE_SIZE +: IDX_W];
   assign wr_lane = mm_wr_addr_i[DCACHE_BYTE_SIZE +: IDX_W];
   assign arr_we  = mm_wr_req_i & ~rst_i;

   segre_mm_array #(
      .NUM_LANES (MM_NUM_LANES),
      .IDX_W     (IDX_W)
   ) u_array (
      .clk_i     (clk_i),
      .we_i      (arr_we),
      .wr_idx_i  (wr_lane),
      .wr_data_i (mm_data_i),
      .rd_idx_i  (idx_q),
      .rd_data_o (arr_rd_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      rdy_d   = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         MM_IDLE: begin
            if (mm_rd_req_i) begin
               idx_d   = rd_lane;
               cnt_d   = 8'(MM_RD_LATENCY - 1);
               state_d = MM_BUSY;
            end
         end
         MM_BUSY: begin
            cnt_d = cnt_q - 8'd1;
            if (mm_rd_req_i) begin
               err_d = 1'b1;
            end
            if (cnt_q == 8'd1) begin
               // The array write lands on this same edge, so bypass it to the response.
               data_d  = (mm_wr_req_i && (wr_lane == idx_q)) ? mm_data_i : arr_rd_data;
               state_d = MM_RESP;
            end
         end
         MM_RESP: begin
            rdy_d   = 1'b1;
            state_d = MM_IDLE;
            if (mm_rd_req_i) begin
               err_d = 1'b1;
            end
         end
         default: state_d = MM_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= MM_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
      end
   end

   assign mm_data_rdy_o = rdy_q;
   assign mm_data_o     = data_q;
   assign mm_err_o      = err_q;

`ifdef SEGRE_MM_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if ((state_q == MM_IDLE) && mm_rd_req_i && (rd_cnt_q != 32'hFFFF_FFFF)) begin
         rd_cnt_d = rd_cnt_q + 32'd1;
      end
      if (mm_wr_req_i && (wr_cnt_q != 32'hFFFF_FFFF)) begin
         wr_cnt_d = wr_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign mm_rd_cnt_o = rd_cnt_q;
   assign mm_wr_cnt_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_segre_mm_ctrl.sv
// tb/tb_segre_mm_ctrl.sv - self-checking bench for segre_mm_ctrl; SEGRE_MM_STATS_EN enables counter checks.
module tb_segre_mm_ctrl;
   import segre_pkg::*;

   localparam int LAT   = 10;
   localparam int LANES = 1024;

   logic                        clk_i = 1'b0;
   logic                        rst_i = 1'b1;
   logic                        mm_rd_req_i = 1'b0;
   logic [ADDR_SIZE-1:0]        mm_addr_i = '0;
   logic                        mm_wr_req_i = 1'b0;
   logic [ADDR_SIZE-1:0]        mm_wr_addr_i = '0;
   logic [DCACHE_LANE_SIZE-1:0] mm_data_i = '0;
   logic                        mm_data_rdy_o;
   logic [DCACHE_LANE_SIZE-1:0] mm_data_o;
   logic                        mm_err_o;
`ifdef SEGRE_MM_STATS_EN
   logic [31:0]                 mm_rd_cnt_o;
   logic [31:0]                 mm_wr_cnt_o;
`endif

   segre_mm_ctrl #(
      .MM_RD_LATENCY (LAT),
      .MM_NUM_LANES  (LANES)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .mm_rd_req_i   (mm_rd_req_i),
      .mm_addr_i     (mm_addr_i),
      .mm_wr_req_i   (mm_wr_req_i),
      .mm_wr_addr_i  (mm_wr_addr_i),
      .mm_data_i     (mm_data_i),
      .mm_data_rdy_o (mm_data_rdy_o),
      .mm_data_o     (mm_data_o),
      .mm_err_o      (mm_err_o)
`ifdef SEGRE_MM_STATS_EN
      ,
      .mm_rd_cnt_o   (mm_rd_cnt_o),
      .mm_wr_cnt_o   (mm_wr_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [DCACHE_LANE_SIZE-1:0] act,
                      input logic [DCACHE_LANE_SIZE-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: lane memory plus one outstanding read with absolute edge numbers.
   logic [DCACHE_LANE_SIZE-1:0] mem [int];
   int                          edge_no = 0;
   bit                          started = 0;
   bit                          pend = 0;
   int                          pend_lane, load_edge, rdy_edge;
   logic [DCACHE_LANE_SIZE-1:0] m_data = '0;
   logic                        m_rdy = 1'b0;
   logic                        m_err = 1'b0;
   int                          m_rd_cnt = 0;
   int                          m_wr_cnt = 0;

   function automatic int lane_of(input logic [ADDR_SIZE-1:0] a);
      return int'((a / 64) % LANES);
   endfunction

   always @(posedge clk_i) begin
      bit was_busy;
      edge_no++;
      started = 1;
      if (rst_i) begin
         pend = 0; m_data = '0; m_rdy = 1'b0; m_err = 1'b0;
         m_rd_cnt = 0; m_wr_cnt = 0;
      end else begin
         was_busy = pend;
         if (mm_wr_req_i) begin
            mem[lane_of(mm_wr_addr_i)] = mm_data_i;
            m_wr_cnt++;
         end
         if (pend && edge_no == load_edge) m_data = mem[pend_lane];
         if (pend && edge_no == rdy_edge) begin
            m_rdy = 1'b1;
            pend  = 0;
         end else begin
            m_rdy = 1'b0;
         end
         if (mm_rd_req_i) begin
            if (was_busy) begin
               m_err = 1'b1;
            end else begin
               pend      = 1;
               pend_lane = lane_of(mm_addr_i);
               load_edge = edge_no + LAT - 1;
               rdy_edge  = edge_no + LAT;
               m_rd_cnt++;
            end
         end
      end
   end

   always @(negedge clk_i) begin
      if (started) begin
         chk("rdy",  DCACHE_LANE_SIZE'(mm_data_rdy_o), DCACHE_LANE_SIZE'(m_rdy));
         chk("err",  DCACHE_LANE_SIZE'(mm_err_o),      DCACHE_LANE_SIZE'(m_err));
         chk("data", mm_data_o, m_data);
`ifdef SEGRE_MM_STATS_EN
         chk("rd_cnt", DCACHE_LANE_SIZE'(mm_rd_cnt_o), DCACHE_LANE_SIZE'(m_rd_cnt));
         chk("wr_cnt", DCACHE_LANE_SIZE'(mm_wr_cnt_o), DCACHE_LANE_SIZE'(m_wr_cnt));
`endif
      end
   end

   task automatic drive(input logic rd, input logic [ADDR_SIZE-1:0] ra, input logic wr,
                        input logic [ADDR_SIZE-1:0] wa, input logic [DCACHE_LANE_SIZE-1:0] wd);
      mm_rd_req_i  = rd;
      mm_addr_i    = ra;
      mm_wr_req_i  = wr;
      mm_wr_addr_i = wa;
      mm_data_i    = wd;
      @(posedge clk_i);
      #1;
      mm_rd_req_i = 1'b0;
      mm_wr_req_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic wait_rdy(input string nm, input int exp_edges,
                           input logic [DCACHE_LANE_SIZE-1:0] exp_data);
      int k = 0;
      int seen = -1;
      while (k < 40 && seen < 0) begin
         @(posedge clk_i);
         #1;
         k++;
         if (mm_data_rdy_o) seen = k;
      end
      chk({nm, "_latency"}, DCACHE_LANE_SIZE'(seen), DCACHE_LANE_SIZE'(exp_edges));
      chk({nm, "_data"}, mm_data_o, exp_data);
   endtask

   localparam logic [DCACHE_LANE_SIZE-1:0] PAT_A5   = {16{32'hA5A5_A5A5}};
   localparam logic [DCACHE_LANE_SIZE-1:0] PAT_DEAD = {16{32'hDEAD_BEEF}};
   localparam logic [DCACHE_LANE_SIZE-1:0] PAT_FF   = {16{32'hFFFF_FFFF}};

   initial begin
      rst_i = 1'b1;
      idle(2);
      chk("reset_rdy",  DCACHE_LANE_SIZE'(mm_data_rdy_o), '0);
      chk("reset_err",  DCACHE_LANE_SIZE'(mm_err_o), '0);
      chk("reset_data", mm_data_o, '0);
      rst_i = 1'b0;
      idle(3);

      // Write lane 1 then read it two cycles later: rdy after edge +10.
      drive(0, '0, 1, 32'h40, PAT_A5);
      idle(1);
      drive(1, 32'h40, 0, '0, '0);
      wait_rdy("basic", 10, PAT_A5);

      // Same-cycle read/write, then a write on the load edge is forwarded.
      drive(1, 32'h80, 1, 32'h80, 512'h1234);
      idle(8);
      drive(0, '0, 1, 32'h80, 512'h5678);
      wait_rdy("fwd_load_edge", 1, 512'h5678);

      // A write one edge after the load edge must not be visible.
      drive(1, 32'h80, 1, 32'h80, 512'h1234);
      idle(9);
      drive(0, '0, 1, 32'h80, 512'h5678);
      chk("late_write_rdy",  DCACHE_LANE_SIZE'(mm_data_rdy_o), 1);
      chk("late_write_data", mm_data_o, 512'h1234);

      // Second read while busy is dropped and raises the sticky error.
      drive(1, 32'h40, 0, '0, '0);
      idle(2);
      drive(1, 32'h80, 0, '0, '0);
      chk("drop_err", DCACHE_LANE_SIZE'(mm_err_o), 1);
      wait_rdy("drop", 7, PAT_A5);
      idle(14);
      chk("drop_err_sticky", DCACHE_LANE_SIZE'(mm_err_o), 1);

      // Reset mid-read aborts it; a write during reset is discarded.
      drive(1, 32'h80, 0, '0, '0);
      idle(3);
      rst_i = 1'b1;
      drive(0, '0, 1, 32'h40, PAT_FF);
      idle(1);
      rst_i = 1'b0;
      chk("rst_rdy",  DCACHE_LANE_SIZE'(mm_data_rdy_o), '0);
      chk("rst_data", mm_data_o, '0);
      chk("rst_err",  DCACHE_LANE_SIZE'(mm_err_o), '0);
      idle(14);
      drive(1, 32'h40, 0, '0, '0);
      wait_rdy("after_rst", 10, PAT_A5);

      // Back-to-back read right after the response cycle, through an aliased address.
      drive(0, '0, 1, 32'h40, PAT_DEAD);
      idle(1);
      drive(1, 32'h40 + LANES * 64, 0, '0, '0);
      wait_rdy("alias", 10, PAT_DEAD);
      drive(1, 32'h7F, 0, '0, '0);
      chk("b2b_no_err", DCACHE_LANE_SIZE'(mm_err_o), '0);
      wait_rdy("byte_offset", 10, PAT_DEAD);

`ifdef SEGRE_MM_STATS_EN
      rst_i = 1'b1;
      idle(1);
      rst_i = 1'b0;
      drive(1, 32'h40, 1, 32'h100, 512'h1);
      drive(0, '0, 1, 32'h140, 512'h2);
      drive(1, 32'h80, 1, 32'h180, 512'h3);
      idle(LAT);
      drive(1, 32'h100, 1, 32'h1C0, 512'h4);
      idle(LAT + 1);
      drive(1, 32'h140, 1, 32'h200, 512'h5);
      idle(LAT + 2);
      chk("stats_rd", DCACHE_LANE_SIZE'(mm_rd_cnt_o), 3);
      chk("stats_wr", DCACHE_LANE_SIZE'(mm_wr_cnt_o), 5);
`endif

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/segre_mm_ctrl.md
SEGRE_MM_CTRL -- requirements
Module: segre_mm_ctrl

Interface
REQ-001 The module SHALL have parameter MM_RD_LATENCY, default 10, meaning the number of cycles from read request to response (legal range 2..255).
REQ-002 The module SHALL have parameter MM_NUM_LANES, default 1024, meaning the storage depth in cache lanes (power of two).
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port mm_rd_req_i, input, 1 bit: read request, one-cycle pulse.
REQ-006 The module SHALL have port mm_addr_i, input, ADDR_SIZE bits: read byte address, lane aligned.
REQ-007 The module SHALL have port mm_wr_req_i, input, 1 bit: write-back request, one-cycle pulse.
REQ-008 The module SHALL have port mm_wr_addr_i, input, ADDR_SIZE bits: write byte address.
REQ-009 The module SHALL have port mm_data_i, input, DCACHE_LANE_SIZE bits: write lane data.
REQ-010 The module SHALL have port mm_data_rdy_o, output, 1 bit: read response valid, one-cycle pulse.
REQ-011 The module SHALL have port mm_data_o, output, DCACHE_LANE_SIZE bits: read response lane data.
REQ-012 The module SHALL have port mm_err_o, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 Lane index SHALL be addr[DCACHE_BYTE_SIZE +: log2(MM_NUM_LANES)]; higher address bits are ignored (wrap-around), and byte-offset bits are ignored.
REQ-014 The FSM SHALL have states MM_IDLE, MM_BUSY and MM_RESP.
REQ-015 In MM_IDLE, mm_rd_req_i=1 SHALL latch the lane index, load the latency counter with MM_RD_LATENCY-1, and move to MM_BUSY.
REQ-016 In MM_BUSY, the counter SHALL decrement each cycle; at the count of 1 the FSM SHALL load mm_data_o from the array and move to MM_RESP.
REQ-017 In MM_RESP, mm_data_rdy_o SHALL be 1 for exactly that cycle, and the FSM SHALL then return to MM_IDLE.
REQ-018 The latency SHALL be as follows: a request sampled at edge 0 makes mm_data_rdy_o high in the cycle following edge MM_RD_LATENCY.
REQ-019 mm_data_o SHALL hold its last value outside MM_RESP.
REQ-020 A read request in MM_BUSY or MM_RESP SHALL be dropped and SHALL set mm_err_o, with no effect on the in-flight read.
REQ-021 A read request SHALL be accepted in the cycle immediately after MM_RESP, giving back-to-back throughput of one read per MM_RD_LATENCY+1 cycles.
REQ-022 Writes SHALL be accepted in any state, every cycle, with no backpressure, and the full lane SHALL be committed at the sampling edge.
REQ-023 Read data SHALL reflect all writes sampled up to and including the edge that loads mm_data_o; a same-lane write in that cycle SHALL be forwarded, and later writes SHALL not be visible.
REQ-024 A simultaneous read request and write to the same lane in MM_IDLE SHALL return the newly written data.

Reset
REQ-025 Reset SHALL force MM_IDLE, counter 0, mm_data_rdy_o 0, mm_data_o 0 and mm_err_o 0.
REQ-026 Reset asserted mid-read SHALL abort the read, and no mm_data_rdy_o pulse SHALL follow.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 Writes sampled while rst_i=1 SHALL be discarded.

Configuration
REQ-029 When SEGRE_MM_STATS_EN is defined, the module SHALL add outputs mm_rd_cnt_o and mm_wr_cnt_o, each 32 bits, counting accepted reads and writes; both saturate at 0xFFFFFFFF and are reset to 0.
REQ-030 When SEGRE_MM_STATS_EN is undefined, these ports and their counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-031 The shared package segre_pkg SHALL hold mm_ctrl_state_e and the MM_RD_LATENCY default; ADDR_SIZE, DCACHE_LANE_SIZE and DCACHE_BYTE_SIZE SHALL be taken from segre_pkg.
REQ-032 The storage array SHALL be a sub-module segre_mm_array: one synchronous write port and one asynchronous read port, MM_NUM_LANES x DCACHE_LANE_SIZE.

Verification
REQ-033 Scenario: write lane 0x40 = 0xA5A5... at cycle 5, then read 0x40 at cycle 7 -> mm_data_rdy_o high in the cycle following edge 17 (MM_RD_LATENCY=10), with data 0xA5A5....
REQ-034 Scenario: read 0x80 while writing 0x80 = 0x1234 in the same cycle, then write 0x80 = 0x5678 nine cycles later (the load edge) -> response 0x5678; a repeat with the write ten cycles later -> response 0x1234.
REQ-035 Scenario: a second read request 3 cycles after the first -> it is dropped, mm_err_o=1 and stays high, and only one rdy pulse occurs.
REQ-036 Scenario: reset asserted 4 cycles into a read -> no rdy pulse, outputs 0, and a new read after reset completes normally.
REQ-037 Scenario: address 0x40 + MM_NUM_LANES*lane_bytes -> aliases lane 1 and returns lane 1's data.
REQ-038 Scenario: with SEGRE_MM_STATS_EN defined, 3 reads and 5 writes (one read dropped) -> mm_rd_cnt_o=3 and mm_wr_cnt_o=5.
